// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: instruction encodings, fetch state, buffer entry.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] INST_NOP    = 32'h0000_0013;
    localparam logic [XLEN-1:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [XLEN-1:0] INST_EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // ECALL and EBREAK both stop further fetching once they are captured
    function automatic logic is_halt_inst(input logic [XLEN-1:0] inst);
        return (inst == INST_ECALL) || (inst == INST_EBREAK);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, inst}; entry 0 is always the head.
module fetch_buffer
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_entry,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    logic [1:0]   r_count;
    fetch_entry_t r_e0;
    fetch_entry_t r_e1;

    // Occupancy: flush wins over any pop/push in the same cycle
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_count <= 2'd0;
        end else if (push && !pop) begin
            r_count <= r_count + 2'd1;
        end else if (pop && !push) begin
            r_count <= r_count - 2'd1;
        end
    end

    // Entry storage; left unreset since occupancy alone says what is valid
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (pop) begin
                if (push && (r_count == 2'd2)) begin
                    r_e0 <= r_e1;
                    r_e1 <= wr_entry;
                end else if (push) begin
                    r_e0 <= wr_entry;
                end else begin
                    r_e0 <= r_e1;
                end
            end else if (push) begin
                if (r_count == 2'd0) begin
                    r_e0 <= wr_entry;
                end else begin
                    r_e1 <= wr_entry;
                end
            end
        end
    end

    assign count = r_count;
    assign head  = r_e0;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the PC, captures imem words, feeds decode.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int              ADDR_W   = 12,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [XLEN-1:0]   imem_data,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_inst,
    output logic              halted,
    output logic              fault
);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;

    logic [1:0]      w_count;
    fetch_entry_t    w_head;
    fetch_entry_t    w_wr_entry;
    logic            w_pop;
    logic            w_push;
    logic            w_flush;
    logic            w_pc_ok;
    logic            w_room;

    // PC must be word aligned and inside the memory; pc+4 overflow lands here too
    assign w_pc_ok    = (r_pc[1:0] == 2'b00) && (r_pc[XLEN-1:ADDR_W] == '0);
    assign w_pop      = out_valid && out_ready;
    assign w_room     = (w_count != 2'd2) || w_pop;
    assign w_push     = (r_state == ST_RUN) && !redirect_valid && w_room && w_pc_ok;
    // A redirect into an idle HALT/FAULT stage is ignored so those states stay sticky
    assign w_flush    = redirect_valid && ((r_state == ST_RUN) || (w_count != 2'd0));
    assign w_wr_entry = '{pc: r_pc, inst: imem_data};

    // PC and fetch state; redirect takes priority over everything else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
        end else if (w_flush) begin
            r_state <= ST_RUN;
            r_pc    <= redirect_pc;
        end else if (!redirect_valid && (r_state == ST_RUN)) begin
            if (!w_pc_ok) begin
                r_state <= ST_FAULT;
            end else if (w_push) begin
                r_pc <= r_pc + 32'd4;
                if (is_halt_inst(imem_data)) begin
                    r_state <= ST_HALT;
                end
            end
        end
    end

    fetch_buffer u_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (w_push),
        .pop      (w_pop),
        .flush    (w_flush),
        .wr_entry (w_wr_entry),
        .count    (w_count),
        .head     (w_head)
    );

    assign imem_addr = r_pc[ADDR_W-1:0];
    assign out_valid = (w_count != 2'd0);
    assign out_pc    = out_valid ? w_head.pc   : '0;
    assign out_inst  = out_valid ? w_head.inst : INST_NOP;
    assign halted    = (r_state == ST_HALT);
    assign fault     = (r_state == ST_FAULT);

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end that sits directly upstream of the 4 KB byte-addressed instruction memory and feeds decode. It owns the program counter and drives the memory's 12-bit byte address. It captures the combinationally returned 32-bit little-endian word into a 2-entry buffer and presents {pc, inst} to decode over a valid/ready handshake. It also handles control-flow redirects, detects out-of-range or misaligned fetch, and stops fetching on ECALL/EBREAK.

## Interface
- ADDR_W, 12, instruction-memory byte-address width (memory size 2^ADDR_W bytes)
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- imem_addr  out  ADDR_W  byte address to instruction memory, = pc[ADDR_W-1:0]
- imem_data  in  32  instruction word returned combinationally for imem_addr
- redirect_valid  in  1  taken branch/jump from execute; flushes the buffer
- redirect_pc  in  32  redirect target byte address
- out_valid  out  1  buffer head valid toward decode
- out_ready  in  1  decode accepts head this cycle
- out_pc  out  32  PC of head instruction
- out_inst  out  32  head instruction word
- halted  out  1  state is HALT
- fault  out  1  state is FAULT

## Operation
- States: RUN, HALT, FAULT. Reset: state=RUN, pc=RESET_PC, count=0.
- pop = out_valid & out_ready. push = (state==RUN) & !redirect_valid & (count<2 | pop) & pc_ok.
- pc_ok: pc[1:0]==0 and pc[31:ADDR_W]==0. In RUN with !pc_ok and no redirect: enter FAULT and do not push.
- On push: enqueue {pc, imem_data}; pc <= pc+4.
- Pushed word is 32'h0000_0073 (ECALL) or 32'h0010_0073 (EBREAK): enter HALT after the push. No further fetch happens.
- Redirect has highest priority in every state. If state==RUN, or the buffer is non-empty (count>0): flush (count<=0, this cycle's pop ignored), pc<=redirect_pc, state<=RUN. In HALT/FAULT with count==0 the redirect is ignored and the state stays sticky; only rst leaves it.
- A misaligned or out-of-range redirect target faults on the following cycle via the pc_ok rule.
- HALT/FAULT: the buffer keeps draining normally; no pushes occur.
- Simultaneous push and pop at count==2 is legal: count stays 2.
- When out_valid=0: out_inst=32'h0000_0013 (NOP), out_pc=0.
- pc+4 is a 32-bit addition; overflow past 2^ADDR_W is caught by pc_ok and never wraps into the memory.

## Timing
- Reset values: out_valid=0, out_pc=0, out_inst=32'h13, halted=0, fault=0, imem_addr=RESET_PC[ADDR_W-1:0].
- The first push occurs at the first edge with rst low; out_valid=1 in the following cycle.
- Fetch-to-output latency: 1 cycle. Throughput: 1 instruction/cycle with out_ready held high.
- Redirect sampled at edge N: pc=target after N, target pushed at N+1, out_valid after N+1. This is one bubble cycle.
- While out_valid=1 and out_ready=0, out_pc and out_inst are held stable.
- halted and fault are registered state decodes, asserted the cycle after the triggering edge.
- rst asserted mid-stream: all state returns to reset values at that edge, and buffer contents are discarded.

## Structure
- Shared package riscv_pkg: ECALL/EBREAK/NOP encodings, fetch state enum, XLEN=32.
- Sub-module fetch_buffer: a 2-entry synchronous FIFO of 64-bit {pc, inst} entries. Ports: push, pop, flush, count, head. It takes clk and the same synchronous rst.

## Test plan
- Reset, memory preloaded with sequential ADDIs, out_ready=1 -> out_pc 0x0, 0x4, 0x8, … on consecutive cycles starting 1 cycle after rst falls; each out_inst matches the memory word.
- out_ready=0 for 4 cycles after reset -> count saturates at 2 and pc holds at 0x8; after release, out_pc 0x0, 0x4, 0x8 with no drop or duplicate.
- Redirect to 0x0D4 with 2 entries buffered -> buffer flushed, one out_valid=0 cycle, next out_pc=0x0D4.
- Redirect to 0x102 (misaligned), and separately to 0x1000 -> fault=1 after one cycle, out_valid=0 once drained; fault stays sticky through later redirects until rst.
- ECALL at 0x10 -> pushed and delivered, halted=1, imem never presents a fetch of 0x14. Redirect to 0x40 while the ECALL is still buffered -> halted=0, next out_pc=0x40.
- rst pulsed while count=2 and out_ready=0 -> next cycle out_valid=0 and imem_addr=RESET_PC; fetch resumes from RESET_PC.
